// File: rtl/io_output_bank.sv
// io_output_bank: bank of memory-mapped output ports. Each port supports
// load/set/clear/toggle writes. A timed write also starts a per-port hold
// timer that forces the port back to zero when it expires.
module io_output_bank #(
  parameter int unsigned NPORTS    = 4,
  parameter int unsigned WIDTH     = 32,
  parameter logic [5:0]  BASE_IDX  = 6'b100000,
  parameter int unsigned PULSE_LEN = 1000
) (
  input  logic                     io_clk,
  input  logic                     clm,
  input  logic [31:0]              addr,
  input  logic [WIDTH-1:0]         datain,
  input  logic                     write_io_enable,
  output logic [NPORTS*WIDTH-1:0]  out_ports,
  output logic [WIDTH-1:0]         readback,
  output logic [NPORTS-1:0]        timer_active,
  output logic                     write_hit
);

  logic [WIDTH-1:0]  port_q  [NPORTS];
  logic [WIDTH-1:0]  port_d  [NPORTS];
  logic [15:0]       timer_q [NPORTS];
  logic [15:0]       timer_d [NPORTS];
  logic [NPORTS-1:0] active_q, active_d;
  logic              hit_q, hit_d;

  // Only addr[10:2] take part in decoding.
  logic unused_addr;
  assign unused_addr = ^{addr[31:11], addr[1:0]};

  // A word index below BASE_IDX wraps into bit 6 of rel, so the range check
  // rejects it along with indices at or beyond NPORTS.
  logic [6:0] rel;
  logic       in_range;
  logic       accept;
  assign rel      = {1'b0, addr[7:2]} - {1'b0, BASE_IDX};
  assign in_range = (rel < 7'(NPORTS));
  assign accept   = write_io_enable && in_range;

  // Combinational readback of the addressed port.
  always_comb begin
    readback = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (in_range && (rel == 7'(p))) readback = port_q[p];
    end
  end

  // Next-state: a write to a port takes priority over its timer expiry.
  always_comb begin
    hit_d    = accept;
    active_d = active_q;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      port_d[p]  = port_q[p];
      timer_d[p] = timer_q[p];
      if (accept && (rel == 7'(p))) begin
        unique case (addr[9:8])
          2'b00:   port_d[p] = datain;
          2'b01:   port_d[p] = port_q[p] | datain;
          2'b10:   port_d[p] = port_q[p] & ~datain;
          default: port_d[p] = port_q[p] ^ datain;
        endcase
        if (addr[10]) begin
          timer_d[p]  = 16'(PULSE_LEN);
          active_d[p] = 1'b1;
        end else begin
          timer_d[p]  = '0;
          active_d[p] = 1'b0;
        end
      end else if (active_q[p]) begin
        if (timer_q[p] == 16'd1) begin
          port_d[p]   = '0;
          timer_d[p]  = '0;
          active_d[p] = 1'b0;
        end else begin
          timer_d[p] = timer_q[p] - 16'd1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge io_clk) begin
    if (clm) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        port_q[p]  <= '0;
        timer_q[p] <= '0;
      end
      active_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        port_q[p]  <= port_d[p];
        timer_q[p] <= timer_d[p];
      end
      active_q <= active_d;
      hit_q    <= hit_d;
    end
  end

  // Flatten port registers onto the output bus.
  always_comb begin
    out_ports = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      out_ports[p*WIDTH +: WIDTH] = port_q[p];
    end
  end

  assign timer_active = active_q;
  assign write_hit    = hit_q;

endmodule

// File: tb/tb_io_output_bank.sv
// Testbench for io_output_bank: directed scenarios plus random traffic,
// checked through an expected-value queue against a cycle-count model.
module tb_io_output_bank;
  localparam int unsigned NPORTS = 4;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned BASE   = 32;
  localparam int unsigned PLEN   = 5;

  logic                    clk = 1'b0;
  logic                    clm = 1'b1;
  logic [31:0]             addr = '0;
  logic [WIDTH-1:0]        datain = '0;
  logic                    we = 1'b0;
  logic [NPORTS*WIDTH-1:0] out_ports;
  logic [WIDTH-1:0]        readback;
  logic [NPORTS-1:0]       timer_active;
  logic                    write_hit;

  io_output_bank #(
    .NPORTS(NPORTS), .WIDTH(WIDTH), .BASE_IDX(6'd32), .PULSE_LEN(PLEN)
  ) dut (
    .io_clk(clk), .clm(clm), .addr(addr), .datain(datain),
    .write_io_enable(we), .out_ports(out_ports), .readback(readback),
    .timer_active(timer_active), .write_hit(write_hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NPORTS*WIDTH-1:0] op;
    logic [NPORTS-1:0]       ta;
    logic                    hit;
    logic [WIDTH-1:0]        rb;
  } exp_t;

  exp_t expq[$];
  int vectors = 0;
  int errors  = 0;

  // Reference model: port values, and absolute cycle at which each port's
  // pulse ends (valid only while m_act is set).
  logic [WIDTH-1:0] m_port [NPORTS];
  bit               m_act  [NPORTS];
  longint           m_end  [NPORTS];
  longint           cyc = 0;

  task automatic model_step(input logic r, input logic [31:0] a,
                            input logic [WIDTH-1:0] d, input logic w);
    int idx, p;
    bit acc;
    exp_t e;
    cyc++;
    idx = int'(a[7:2]);
    acc = w && idx >= int'(BASE) && idx < int'(BASE + NPORTS);
    p   = idx - int'(BASE);
    if (r) begin
      for (int q = 0; q < NPORTS; q++) begin
        m_port[q] = '0; m_act[q] = 0; m_end[q] = 0;
      end
      acc = 0;
    end else begin
      for (int q = 0; q < NPORTS; q++) begin
        if (acc && q == p) begin
          case (a[9:8])
            2'd0: m_port[q] = d;
            2'd1: m_port[q] = m_port[q] | d;
            2'd2: m_port[q] = m_port[q] & ~d;
            default: m_port[q] = m_port[q] ^ d;
          endcase
          m_act[q] = a[10];
          m_end[q] = cyc + PLEN;
        end else if (m_act[q] && cyc == m_end[q]) begin
          m_port[q] = '0;
          m_act[q]  = 0;
        end
      end
    end
    for (int q = 0; q < NPORTS; q++) begin
      e.op[q*WIDTH +: WIDTH] = m_port[q];
      e.ta[q] = m_act[q];
    end
    e.hit = acc;
    e.rb  = (idx >= int'(BASE) && idx < int'(BASE + NPORTS)) ? m_port[idx - int'(BASE)] : '0;
    expq.push_back(e);
  endtask

  task automatic do_cycle(input logic r, input logic [31:0] a,
                          input logic [WIDTH-1:0] d, input logic w);
    @(negedge clk);
    clm = r; addr = a; datain = d; we = w;
    @(posedge clk);
    model_step(r, a, d, w);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) do_cycle(1'b0, a, $urandom, 1'b0);
  endtask

  // Monitor: each edge with a pending expectation is compared 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        vectors++;
        if (out_ports !== e.op) begin
          errors++;
          $display("FAIL out_ports t=%0t got %h exp %h", $time, out_ports, e.op);
        end
        if (timer_active !== e.ta) begin
          errors++;
          $display("FAIL timer_active t=%0t got %b exp %b", $time, timer_active, e.ta);
        end
        if (write_hit !== e.hit) begin
          errors++;
          $display("FAIL write_hit t=%0t got %b exp %b", $time, write_hit, e.hit);
        end
        if (readback !== e.rb) begin
          errors++;
          $display("FAIL readback t=%0t got %h exp %h", $time, readback, e.rb);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int idx;
    for (int q = 0; q < NPORTS; q++) begin
      m_port[q] = '0; m_act[q] = 0; m_end[q] = 0;
    end

    do_cycle(1'b1, 32'h80, 32'h1234, 1'b1);
    do_cycle(1'b1, 32'h80, 32'h0, 1'b0);

    // Load and set on two ports, then read back.
    do_cycle(1'b0, 32'h80, 32'hA5A5_0000, 1'b1);
    do_cycle(1'b0, 32'h184, 32'h0000_00FF, 1'b1);
    idle(2, 32'h80);

    // Load, clear, toggle.
    do_cycle(1'b0, 32'h80, 32'hF0F0_F0F0, 1'b1);
    do_cycle(1'b0, 32'h280, 32'h0000_00F0, 1'b1);
    do_cycle(1'b0, 32'h380, 32'hFFFF_FFFF, 1'b1);
    idle(1, 32'h80);

    // Timed load on port 0.
    do_cycle(1'b0, 32'h480, 32'h1, 1'b1);
    idle(7, 32'h80);

    // Timed write on port 2 cancelled by an untimed write.
    do_cycle(1'b0, 32'h488, 32'h3, 1'b1);
    idle(2, 32'h88);
    do_cycle(1'b0, 32'h88, 32'h7, 1'b1);
    idle(8, 32'h88);
    // Timed write on port 2 restarted by another timed write.
    do_cycle(1'b0, 32'h488, 32'h3, 1'b1);
    idle(2, 32'h88);
    do_cycle(1'b0, 32'h588, 32'h10, 1'b1);
    idle(8, 32'h88);
    // Write landing exactly on the expiry edge.
    do_cycle(1'b0, 32'h48C, 32'h5, 1'b1);
    idle(4, 32'h8C);
    do_cycle(1'b0, 32'h18C, 32'h8, 1'b1);
    idle(3, 32'h8C);

    // Out-of-range writes above and below the bank.
    do_cycle(1'b0, 32'h90, 32'hDEAD_BEEF, 1'b1);
    do_cycle(1'b0, 32'h7C, 32'hDEAD_BEEF, 1'b1);
    idle(1, 32'h90);
    idle(1, 32'h7C);

    // Reset while two timers run.
    do_cycle(1'b0, 32'h480, 32'hAAAA, 1'b1);
    do_cycle(1'b0, 32'h484, 32'h5555, 1'b1);
    idle(1, 32'h84);
    do_cycle(1'b1, 32'h484, 32'h1, 1'b1);
    idle(PLEN + 2, 32'h80);

    // Random traffic concentrated around the port window.
    for (int i = 0; i < 800; i++) begin
      idx = int'(BASE) - 1 + int'($urandom_range(0, NPORTS + 1));
      a = $urandom;
      a[7:2]  = 6'(idx);
      a[10]   = ($urandom_range(0, 9) < 3);
      do_cycle(($urandom_range(0, 99) < 2), a, $urandom,
               ($urandom_range(0, 9) < 6));
    end
    idle(PLEN + 2, 32'h80);

    @(negedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
